// File: rtl/muldiv_pkg.sv
// Shared ALU op codes, sequencer state encoding and op-class helpers
// for the multiply/divide unit.
package muldiv_pkg;

    // ALU operation codes (shared with ALU control and the ALU itself)
    localparam logic [2:0] FORWARD = 3'b000;
    localparam logic [2:0] OR      = 3'b001;
    localparam logic [2:0] ADD     = 3'b010;
    localparam logic [2:0] MFHI    = 3'b011;
    localparam logic [2:0] MFLO    = 3'b100;
    localparam logic [2:0] MUL     = 3'b101;
    localparam logic [2:0] SUB     = 3'b110;
    localparam logic [2:0] DIV     = 3'b111;

    // Sequencer state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Ops that launch a multi-cycle computation
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MUL) || (op == DIV);
    endfunction

    // Ops that depend on HI/LO and therefore must wait while busy
    function automatic logic is_hilo_op(input logic [2:0] op);
        return (op == MUL) || (op == DIV) || (op == MFHI) || (op == MFLO);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: one unsigned shift-add multiply step or one
// restoring divide step per cycle. A single 2*WIDTH accumulator serves
// both ops: {product_hi, multiplier/product_lo} for MUL and
// {remainder, quotient} for DIV, so the result is always {HI, LO}.
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor
    logic               is_div_q, is_div_d;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   diff;

    // One iteration of the selected algorithm applied to the current accumulator
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff    = {1'b0, rem_sh} - {2'b00, opnd_q};
        if (is_div_q) begin
            // Non-negative trial difference always fits in WIDTH bits (it is < divisor)
            if (!diff[WIDTH+1])
                acc_step = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            // Carry out of the add becomes the new accumulator MSB after the shift
            if (acc_q[0])
                acc_step = {mul_sum, acc_q[WIDTH-1:1]};
            else
                acc_step = {1'b0, acc_q[2*WIDTH-1:1]};
        end
    end

    // Next-state select: load operands, iterate, or hold
    always_comb begin
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        if (load_i) begin
            is_div_d = is_div_i;
            acc_d    = is_div_i ? {{WIDTH{1'b0}}, a_i} : {{WIDTH{1'b0}}, b_i};
            opnd_d   = is_div_i ? b_i : a_i;
        end else if (step_i) begin
            acc_d = acc_step;
        end
    end

    // Datapath registers, cleared by synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
        end
    end

    // Result of the iteration in progress, captured by the sequencer on the final step
    assign res_hi_o = acc_step[2*WIDTH-1:WIDTH];
    assign res_lo_o = acc_step[WIDTH-1:0];

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV unit with HI/LO registers. Owns the IDLE/RUN/DONE
// FSM, iteration counter, HI/LO and the MFHI/MFLO read mux; the per-cycle
// arithmetic lives in muldiv_iter_core.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       ALUCtl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ReadData,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut,
    output logic             Busy,
    output logic             Done,
    output logic             Stall
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             core_load, core_step;
    logic [WIDTH-1:0] res_hi, res_lo;

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .Clk      (Clk),
        .Reset    (Reset),
        .load_i   (core_load),
        .step_i   (core_step),
        .is_div_i (ALUCtl == DIV),
        .a_i      (A),
        .b_i      (B),
        .res_hi_o (res_hi),
        .res_lo_o (res_lo)
    );

    // FSM: accept in IDLE, iterate WIDTH times in RUN, one-cycle DONE
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start && is_muldiv(ALUCtl)) begin
                    if (ALUCtl == DIV && B == '0) begin
                        // Divide by zero resolves immediately without iterating
                        hi_d    = A;
                        lo_d    = '1;
                        state_d = DONE;
                    end else begin
                        core_load = 1'b1;
                        cnt_d     = CNT_W'(WIDTH - 1);
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                core_step = 1'b1;
                if (cnt_q == '0) begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counter and HI/LO registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Status outputs and the combinational HI/LO read port
    always_comb begin
        Busy  = (state_q == RUN) || (state_q == DONE);
        Done  = (state_q == DONE);
        Stall = Busy && Start && is_hilo_op(ALUCtl);
        if (ALUCtl == MFHI)
            ReadData = hi_q;
        else if (ALUCtl == MFLO)
            ReadData = lo_q;
        else
            ReadData = '0;
    end

    assign HiOut = hi_q;
    assign LoOut = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table,
// random ops against an arithmetic reference, and hand-written
// stall / reset corner-case sequences.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Reset, Start;
    logic [2:0]   ALUCtl;
    logic [W-1:0] A, B;
    logic [W-1:0] ReadData, HiOut, LoOut;
    logic         Busy, Done, Stall;

    int tests = 0;
    int fails = 0;

    muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ALUCtl(ALUCtl),
        .A(A), .B(B), .ReadData(ReadData), .HiOut(HiOut), .LoOut(LoOut),
        .Busy(Busy), .Done(Done), .Stall(Stall)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b, hi, lo;
        int           lat;
        bit           rd;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the operation definition
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, b,
                                  output logic [W-1:0] hi, lo, output int lat);
        logic [63:0] p;
        if (op == MUL) begin
            p   = {32'b0, a} * {32'b0, b};
            hi  = p[63:32];
            lo  = p[31:0];
            lat = W + 1;
        end else if (b == 0) begin
            hi  = a;
            lo  = '1;
            lat = 1;
        end else begin
            hi  = a % b;
            lo  = a / b;
            lat = W + 1;
        end
    endfunction

    // Issue one op from IDLE, measure cycles to Done, check HI/LO (and reads if rd)
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, b,
                          input logic [W-1:0] ehi, elo, input int elat, input bit rd);
        int n;
        bit busy_ok;
        @(negedge Clk);
        Start = 1'b1; ALUCtl = op; A = a; B = b;
        #1 chk("stall_idle", 64'(Stall), 64'(0));
        @(posedge Clk);
        #1 Start = 1'b0; ALUCtl = FORWARD;
        n = 0; busy_ok = 1'b1;
        do begin
            @(negedge Clk);
            n++;
            if (!Busy) busy_ok = 1'b0;
        end while (!Done && n < 100);
        chk("latency", 64'(n), 64'(elat));
        chk("busy_during_op", 64'(busy_ok), 64'(1));
        chk("hi", 64'(HiOut), 64'(ehi));
        chk("lo", 64'(LoOut), 64'(elo));
        if (rd) begin
            @(negedge Clk);
            chk("busy_after_done", 64'(Busy), 64'(0));
            Start = 1'b1; ALUCtl = MFHI;
            #1 chk("mfhi_data", 64'(ReadData), 64'(ehi));
            chk("mfhi_stall", 64'(Stall), 64'(0));
            ALUCtl = MFLO;
            #1 chk("mflo_data", 64'(ReadData), 64'(elo));
            chk("mflo_stall", 64'(Stall), 64'(0));
            Start = 1'b0; ALUCtl = FORWARD;
        end
    endtask

    // Non-MUL/DIV codes with Start must not launch anything
    task automatic ignore_op(input logic [2:0] op);
        logic [W-1:0] h, l;
        h = HiOut; l = LoOut;
        @(negedge Clk);
        Start = 1'b1; ALUCtl = op; A = $urandom; B = $urandom;
        @(posedge Clk);
        #1 Start = 1'b0; ALUCtl = FORWARD;
        @(negedge Clk);
        chk("ignored_op_busy", 64'(Busy), 64'(0));
        chk("ignored_op_hilo", {HiOut, LoOut}, {h, l});
    endtask

    vec_t vt[9];

    initial begin
        logic [W-1:0] ehi, elo, last_hi, last_lo, ra, rb;
        logic [2:0]   rop;
        logic [2:0]   junk[4];
        int           elat, n;
        bit           stall_ok, hold_ok, done_seen;

        vt[0] = '{MUL, 32'd6,         32'd7,         32'h0,         32'h2A,        W+1, 1'b1};
        vt[1] = '{MUL, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  32'h1,         W+1, 1'b1};
        vt[2] = '{DIV, 32'd100,       32'd7,         32'd2,         32'd14,        W+1, 1'b0};
        vt[3] = '{DIV, 32'd5,         32'd9,         32'd5,         32'd0,         W+1, 1'b1};
        vt[4] = '{DIV, 32'h12345678,  32'h0,         32'h12345678,  32'hFFFFFFFF,  1,   1'b1};
        vt[5] = '{MUL, 32'h80000000,  32'd2,         32'h1,         32'h0,         W+1, 1'b0};
        vt[6] = '{DIV, 32'hFFFFFFFF,  32'd1,         32'h0,         32'hFFFFFFFF,  W+1, 1'b1};
        vt[7] = '{DIV, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h0,         32'h1,         W+1, 1'b0};
        vt[8] = '{DIV, 32'd7,         32'h80000000,  32'd7,         32'h0,         W+1, 1'b1};
        junk[0] = FORWARD; junk[1] = OR; junk[2] = ADD; junk[3] = SUB;

        Reset = 1'b1; Start = 1'b0; ALUCtl = FORWARD; A = '0; B = '0;
        repeat (3) @(negedge Clk);
        chk("reset_busy", 64'(Busy), 64'(0));
        chk("reset_done", 64'(Done), 64'(0));
        chk("reset_hilo", {HiOut, LoOut}, 64'(0));
        Reset = 1'b0;

        // Directed table (vt[2] -> vt[3] runs back-to-back)
        for (int i = 0; i < 9; i++)
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].lat, vt[i].rd);
        last_hi = vt[8].hi; last_lo = vt[8].lo;

        // Randomized ops against the reference model
        for (int i = 0; i < 25; i++) begin
            ignore_op(junk[$urandom_range(0, 3)]);
            rop = $urandom_range(0, 1) ? MUL : DIV;
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, ehi, elo, elat);
            run_op(rop, ra, rb, ehi, elo, elat, 1'($urandom_range(0, 1)));
            last_hi = ehi; last_lo = elo;
        end

        // Stall sequence: MFLO and a DIV presented while a MUL runs
        @(negedge Clk);
        Start = 1'b1; ALUCtl = MUL; A = 32'd3; B = 32'd5;
        @(posedge Clk);
        #1 Start = 1'b0; ALUCtl = FORWARD;
        repeat (3) @(negedge Clk);
        Start = 1'b1; ALUCtl = MFLO;
        #1 chk("mflo_busy_stall", 64'(Stall), 64'(1));
        chk("mflo_busy_old_lo", 64'(ReadData), 64'(last_lo));
        @(negedge Clk);
        ALUCtl = DIV; A = 32'd50; B = 32'd6;
        stall_ok = 1'b1; hold_ok = 1'b1; n = 0;
        do begin
            #1 if (!Stall) stall_ok = 1'b0;
            if (!Done && (HiOut !== last_hi || LoOut !== last_lo)) hold_ok = 1'b0;
            @(negedge Clk);
            n++;
        end while (!Done && n < 100);
        chk("stall_while_busy", 64'(stall_ok), 64'(1));
        chk("hilo_held_while_busy", 64'(hold_ok), 64'(1));
        chk("first_op_hilo", {HiOut, LoOut}, {32'd0, 32'd15});
        @(negedge Clk);
        #1 chk("queued_div_stall_idle", 64'(Stall), 64'(0));
        chk("queued_div_busy_idle", 64'(Busy), 64'(0));
        @(posedge Clk);
        #1 Start = 1'b0; ALUCtl = FORWARD;
        n = 0;
        do begin @(negedge Clk); n++; end while (!Done && n < 100);
        chk("queued_div_latency", 64'(n), 64'(W + 1));
        chk("queued_div_hilo", {HiOut, LoOut}, {32'd2, 32'd8});

        // Reset mid-MUL discards everything
        @(negedge Clk);
        Start = 1'b1; ALUCtl = MUL; A = 32'h1234; B = 32'h5678;
        @(posedge Clk);
        #1 Start = 1'b0; ALUCtl = FORWARD;
        repeat (9) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("midreset_busy", 64'(Busy), 64'(0));
        chk("midreset_done", 64'(Done), 64'(0));
        chk("midreset_hilo", {HiOut, LoOut}, 64'(0));
        Reset = 1'b0;
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge Clk);
            if (Done || Busy) done_seen = 1'b1;
        end
        chk("no_done_after_reset", 64'(done_seen), 64'(0));
        chk("hilo_zero_after_reset", {HiOut, LoOut}, 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
